// File: rtl/vai_tx_rr_arbiter.sv
// vai_tx_rr_arbiter
//   Shares one upstream CCI-P Tx request channel among NUM_REQ requesters.
//   Each requester has a private FIFO with a registered almost-full flag.
//   A round-robin scheduler pops one request per cycle onto a registered
//   upstream port and tags each beat with the source index.
//
// Ports
//   pClk           clock, rising edge
//   SoftReset      asynchronous active-high reset
//   req_valid      per-requester push strobe
//   req_data       flat payloads, requester i at [i*REQ_W +: REQ_W]
//   req_almfull    per-requester almost-full (registered)
//   up_almfull     upstream almost-full; blocks new grants while high
//   out_valid      registered upstream request valid
//   out_data       registered payload
//   out_id         index of the granted requester
//   overflow_err   sticky: push attempted into a full FIFO
//   perf_grant_cnt per-requester 32-bit saturating grant counters
//
// Build option
//   VAI_ARB_PERF_CNT_EN : when defined, builds the grant counters;
//                         otherwise perf_grant_cnt is tied to zero.

module vai_tx_rr_arbiter #(
    parameter int unsigned NUM_REQ    = 3,
    parameter int unsigned REQ_W      = 80,
    parameter int unsigned FIFO_DEPTH = 8,
    parameter int unsigned AF_THRESH  = 4,
    localparam int unsigned ID_W      = (NUM_REQ > 2) ? $clog2(NUM_REQ) : 1
) (
    input  logic                     pClk,
    input  logic                     SoftReset,
    input  logic [NUM_REQ-1:0]       req_valid,
    input  logic [NUM_REQ*REQ_W-1:0] req_data,
    output logic [NUM_REQ-1:0]       req_almfull,
    input  logic                     up_almfull,
    output logic                     out_valid,
    output logic [REQ_W-1:0]         out_data,
    output logic [ID_W-1:0]          out_id,
    output logic [NUM_REQ-1:0]       overflow_err,
    output logic [NUM_REQ*32-1:0]    perf_grant_cnt
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] AF_LEVEL = CNT_W'(FIFO_DEPTH - AF_THRESH);
    localparam logic [ID_W-1:0]  LAST_ID  = ID_W'(NUM_REQ - 1);

    logic [REQ_W-1:0] fifoMem [NUM_REQ][FIFO_DEPTH];
    logic [PTR_W-1:0] wrPtr   [NUM_REQ];
    logic [PTR_W-1:0] rdPtr   [NUM_REQ];
    logic [CNT_W-1:0] count   [NUM_REQ];
    logic [CNT_W-1:0] nextCount [NUM_REQ];

    logic [NUM_REQ-1:0] eligible;
    logic [NUM_REQ-1:0] pop;
    logic [NUM_REQ-1:0] accept;
    logic [NUM_REQ-1:0] dropPush;

    logic             grantValid;
    logic [ID_W-1:0]  grantIdx;
    logic [ID_W-1:0]  rrPtr;
    logic [REQ_W-1:0] headData;

    always_comb begin
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            eligible[i] = (count[i] != '0);
        end
    end

    // Scan offsets from farthest to nearest so the eligible requester
    // closest to rrPtr (cyclically) is the last assignment and wins.
    always_comb begin
        int unsigned idx;
        idx        = 0;
        grantValid = 1'b0;
        grantIdx   = '0;
        headData   = '0;
        if (!up_almfull) begin
            for (int unsigned k = NUM_REQ; k > 0; k--) begin
                idx = 32'(rrPtr) + k - 1;
                if (idx >= NUM_REQ) begin
                    idx = idx - NUM_REQ;
                end
                if (eligible[idx]) begin
                    grantValid = 1'b1;
                    grantIdx   = ID_W'(idx);
                    headData   = fifoMem[idx][rdPtr[idx]];
                end
            end
        end
    end

    // A full FIFO still accepts a push in the same cycle it is popped.
    always_comb begin
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            pop[i]       = grantValid && (grantIdx == ID_W'(i));
            accept[i]    = req_valid[i] && ((count[i] != FULL_CNT) || pop[i]);
            dropPush[i]  = req_valid[i] && !accept[i];
            nextCount[i] = count[i] + CNT_W'(accept[i]) - CNT_W'(pop[i]);
        end
    end

    always_ff @(posedge pClk) begin
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (accept[i]) begin
                fifoMem[i][wrPtr[i]] <= req_data[i*REQ_W +: REQ_W];
            end
        end
    end

    always_ff @(posedge pClk or posedge SoftReset) begin
        if (SoftReset) begin
            for (int unsigned i = 0; i < NUM_REQ; i++) begin
                wrPtr[i] <= '0;
                rdPtr[i] <= '0;
                count[i] <= '0;
            end
            req_almfull  <= '0;
            overflow_err <= '0;
            rrPtr        <= '0;
            out_valid    <= 1'b0;
            out_data     <= '0;
            out_id       <= '0;
        end else begin
            for (int unsigned i = 0; i < NUM_REQ; i++) begin
                if (accept[i]) begin
                    wrPtr[i] <= wrPtr[i] + 1'b1;
                end
                if (pop[i]) begin
                    rdPtr[i] <= rdPtr[i] + 1'b1;
                end
                if (dropPush[i]) begin
                    overflow_err[i] <= 1'b1;
                end
                count[i]       <= nextCount[i];
                req_almfull[i] <= (nextCount[i] >= AF_LEVEL);
            end
            out_valid <= grantValid;
            if (grantValid) begin
                out_data <= headData;
                out_id   <= grantIdx;
                rrPtr    <= (grantIdx == LAST_ID) ? '0 : grantIdx + 1'b1;
            end
        end
    end

`ifdef VAI_ARB_PERF_CNT_EN
    logic [31:0] grantCnt [NUM_REQ];

    always_ff @(posedge pClk or posedge SoftReset) begin
        if (SoftReset) begin
            for (int unsigned i = 0; i < NUM_REQ; i++) begin
                grantCnt[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < NUM_REQ; i++) begin
                if (pop[i] && (grantCnt[i] != '1)) begin
                    grantCnt[i] <= grantCnt[i] + 32'd1;
                end
            end
        end
    end

    always_comb begin
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            perf_grant_cnt[i*32 +: 32] = grantCnt[i];
        end
    end
`else
    assign perf_grant_cnt = '0;
`endif

endmodule

// File: tb/tb_vai_tx_rr_arbiter.sv
// tb_vai_tx_rr_arbiter
//   Directed bench for vai_tx_rr_arbiter (NUM_REQ=3, REQ_W=80,
//   FIFO_DEPTH=8, AF_THRESH=4). Inputs change and outputs are sampled
//   1 time unit after each rising edge.

module tb_vai_tx_rr_arbiter;

    localparam int NREQ = 3;
    localparam int W    = 80;

    logic              pClk;
    logic              SoftReset;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ*W-1:0] req_data;
    logic [NREQ-1:0]   req_almfull;
    logic              up_almfull;
    logic              out_valid;
    logic [W-1:0]      out_data;
    logic [1:0]        out_id;
    logic [NREQ-1:0]   overflow_err;
    logic [NREQ*32-1:0] perf_grant_cnt;

    int checkCnt = 0;
    int failCnt  = 0;

    vai_tx_rr_arbiter #(
        .NUM_REQ   (3),
        .REQ_W     (80),
        .FIFO_DEPTH(8),
        .AF_THRESH (4)
    ) dut (
        .pClk          (pClk),
        .SoftReset     (SoftReset),
        .req_valid     (req_valid),
        .req_data      (req_data),
        .req_almfull   (req_almfull),
        .up_almfull    (up_almfull),
        .out_valid     (out_valid),
        .out_data      (out_data),
        .out_id        (out_id),
        .overflow_err  (overflow_err),
        .perf_grant_cnt(perf_grant_cnt)
    );

    initial pClk = 1'b0;
    always #5 pClk = ~pClk;

    task automatic checkEq(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        checkCnt++;
        if (got !== exp) begin
            failCnt++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge pClk);
        #1;
    endtask

    function automatic logic [W-1:0] pat(input int i, input int k);
        return {16'hC0DE, 48'h0, 8'(i), 8'(k)};
    endfunction

    task automatic setData(input int i, input logic [W-1:0] v);
        req_data[i*W +: W] = v;
    endtask

    task automatic doReset();
        SoftReset  = 1'b1;
        req_valid  = '0;
        up_almfull = 1'b0;
        tick();
        tick();
        SoftReset = 1'b0;
        tick();
    endtask

    initial begin
        SoftReset  = 1'b1;
        req_valid  = '0;
        req_data   = '0;
        up_almfull = 1'b0;
        tick();
        tick();

        // Reset state
        checkEq("rst_out_valid", W'(out_valid), '0);
        checkEq("rst_out_data", out_data, '0);
        checkEq("rst_out_id", W'(out_id), '0);
        checkEq("rst_almfull", W'(req_almfull), '0);
        checkEq("rst_overflow", W'(overflow_err), '0);
        checkEq("rst_perf", W'(perf_grant_cnt[79:0]), '0);
        SoftReset = 1'b0;
        repeat (3) tick();

        // Single request from requester 1, two-cycle latency, no bypass
        setData(1, W'(80'hA5));
        req_valid = 3'b010;
        tick();
        req_valid = '0;
        checkEq("s1_no_bypass", W'(out_valid), '0);
        tick();
        checkEq("s1_valid", W'(out_valid), 1);
        checkEq("s1_data", out_data, W'(80'hA5));
        checkEq("s1_id", W'(out_id), 1);
        tick();
        checkEq("s1_valid_drop", W'(out_valid), '0);
        checkEq("s1_data_hold", out_data, W'(80'hA5));
        checkEq("s1_id_hold", W'(out_id), 1);
        repeat (3) begin
            tick();
            checkEq("s1_quiet", W'(out_valid), '0);
        end

        // Round-robin over 3 x 4 queued entries
        doReset();
        up_almfull = 1'b1;
        for (int k = 0; k < 4; k++) begin
            for (int i = 0; i < NREQ; i++) setData(i, pat(i, k));
            req_valid = 3'b111;
            tick();
        end
        req_valid = '0;
        checkEq("s2_held", W'(out_valid), '0);
        up_almfull = 1'b0;
        for (int j = 0; j < 12; j++) begin
            tick();
            checkEq($sformatf("s2_valid_%0d", j), W'(out_valid), 1);
            checkEq($sformatf("s2_id_%0d", j), W'(out_id), W'(j % 3));
            checkEq($sformatf("s2_data_%0d", j), out_data, pat(j % 3, j / 3));
        end
        tick();
        checkEq("s2_done", W'(out_valid), '0);
`ifdef VAI_ARB_PERF_CNT_EN
        for (int i = 0; i < NREQ; i++)
            checkEq($sformatf("s2_perf_%0d", i), W'(perf_grant_cnt[i*32 +: 32]), 4);
`else
        for (int i = 0; i < NREQ; i++)
            checkEq($sformatf("s2_perf_%0d", i), W'(perf_grant_cnt[i*32 +: 32]), 0);
`endif

        // Almost-full on requester 0 while upstream is blocked
        doReset();
        up_almfull = 1'b1;
        for (int k = 0; k < 5; k++) begin
            setData(0, pat(0, k));
            req_valid = 3'b001;
            tick();
            checkEq($sformatf("s3_af_push_%0d", k), W'(req_almfull[0]), W'(k >= 3));
            checkEq($sformatf("s3_blocked_%0d", k), W'(out_valid), '0);
        end
        req_valid  = '0;
        up_almfull = 1'b0;
        for (int b = 0; b < 5; b++) begin
            tick();
            checkEq($sformatf("s3_valid_%0d", b), W'(out_valid), 1);
            checkEq($sformatf("s3_data_%0d", b), out_data, pat(0, b));
            checkEq($sformatf("s3_af_drain_%0d", b), W'(req_almfull[0]), W'(b == 0));
        end
        tick();
        checkEq("s3_done", W'(out_valid), '0);

        // Overflow on requester 2
        doReset();
        up_almfull = 1'b1;
        for (int k = 0; k < 9; k++) begin
            setData(2, pat(2, k));
            req_valid = 3'b100;
            tick();
            checkEq($sformatf("s4_ovf_%0d", k), W'(overflow_err), (k == 8) ? W'(3'b100) : '0);
        end
        req_valid  = '0;
        up_almfull = 1'b0;
        for (int b = 0; b < 8; b++) begin
            tick();
            checkEq($sformatf("s4_valid_%0d", b), W'(out_valid), 1);
            checkEq($sformatf("s4_id_%0d", b), W'(out_id), 2);
            checkEq($sformatf("s4_data_%0d", b), out_data, pat(2, b));
        end
        tick();
        checkEq("s4_no_ninth", W'(out_valid), '0);
        checkEq("s4_ovf_sticky", W'(overflow_err), W'(3'b100));

        // Asynchronous reset mid-drain discards queued entries and rr_ptr
        doReset();
        up_almfull = 1'b1;
        for (int k = 0; k < 5; k++) begin
            setData(0, pat(0, k));
            req_valid = 3'b001;
            tick();
        end
        req_valid  = '0;
        up_almfull = 1'b0;
        tick();
        tick();
        checkEq("s5_pre_valid", W'(out_valid), 1);
        checkEq("s5_pre_data", out_data, pat(0, 1));
        SoftReset = 1'b1;
        #1;
        checkEq("s5_async_valid", W'(out_valid), '0);
        checkEq("s5_async_data", out_data, '0);
        tick();
        SoftReset = 1'b0;
        for (int c = 0; c < 5; c++) begin
            tick();
            checkEq($sformatf("s5_flushed_%0d", c), W'(out_valid), '0);
        end
        for (int i = 0; i < NREQ; i++) setData(i, pat(i, 9));
        req_valid = 3'b111;
        tick();
        req_valid = '0;
        for (int j = 0; j < 3; j++) begin
            tick();
            checkEq($sformatf("s5_valid_%0d", j), W'(out_valid), 1);
            checkEq($sformatf("s5_id_%0d", j), W'(out_id), W'(j));
            checkEq($sformatf("s5_data_%0d", j), out_data, pat(j, 9));
        end
        tick();
        checkEq("s5_done", W'(out_valid), '0);

        $display("TB_RESULT checks=%0d failures=%0d", checkCnt, failCnt);
        $finish;
    end

endmodule

// File: doc/vai_tx_rr_arbiter.md
Name: vai_tx_rr_arbiter

Overview:
- Shares one upstream CCI-P Tx request channel (e.g. C0 read requests) among NUM_REQ memcpy sub-AFUs behind the VAI mux.
- Each requester pushes into a private FIFO with almost-full backpressure.
- A round-robin scheduler drains the FIFOs one request per cycle onto a registered upstream port, tagging each beat with the source index for response routing.

Parameters:
- NUM_REQ, 3, number of requesters (2..16); ID_W = max(1, $clog2(NUM_REQ)) is derived locally.
- REQ_W, 80, request payload width (header plus address), passed through unmodified.
- FIFO_DEPTH, 8, per-requester FIFO depth; power of two, >= 4.
- AF_THRESH, 4, almost-full asserts when free slots <= AF_THRESH; range 1..FIFO_DEPTH-1.

Ports:
- pClk  in  1  sole clock, rising edge.
- SoftReset  in  1  asynchronous, active-high reset.
- req_valid  in  NUM_REQ  per-requester push strobe.
- req_data  in  NUM_REQ*REQ_W  flat payloads; requester i occupies bits [i*REQ_W +: REQ_W].
- req_almfull  out  NUM_REQ  per-requester almost-full, registered.
- up_almfull  in  1  upstream almost-full; no new grant while high.
- out_valid  out  1  registered upstream request valid.
- out_data  out  REQ_W  registered payload.
- out_id  out  ID_W  index of the granted requester.
- overflow_err  out  NUM_REQ  sticky flag: push was attempted into a full FIFO.
- perf_grant_cnt  out  NUM_REQ*32  grant counters (see Optional Feature).

Behaviour:
- Reset (asynchronous assert, synchronous deassert handled upstream). While SoftReset is high:
  - out_valid=0, out_data=0, out_id=0.
  - req_almfull=0, overflow_err=0, perf_grant_cnt=0.
  - All FIFO pointers and counts = 0; rr_ptr = 0.
  - Reset mid-operation discards all queued requests; no beat is emitted during or after reset for pre-reset pushes.
- Push:
  - req_valid[i] at edge t writes FIFO i; the entry is eligible from cycle t+1.
  - No bypass: an empty FIFO pushed at t is not eligible at t.
- Push into full FIFO: data dropped, count unchanged, overflow_err[i] <= 1. The flag stays set until reset.
- Simultaneous push and pop on the same FIFO: count unchanged, legal even when full (pop frees the slot first).
- req_almfull[i] <= (next_count_i >= FIFO_DEPTH-AF_THRESH), where next_count_i includes this cycle's push and pop.
- Arbitration, every cycle:
  - eligible[i] = count_i != 0.
  - If up_almfull==0 and eligible is non-zero: grant g = first eligible index searching cyclically from rr_ptr.
  - On a grant: pop FIFO g; next cycle out_valid=1, out_data=head_g, out_id=g; rr_ptr <= (g+1) mod NUM_REQ.
  - If up_almfull==1 or nothing is eligible: out_valid <= 0, rr_ptr holds, out_data/out_id hold their last values.
- Latency: push at t gives earliest out_valid at t+2. Sustained throughput is one beat per cycle.
- up_almfull asserted at cycle t: the beat granted at t-1 still appears at t; nothing is granted at t or later until it deasserts.
- Fairness: with all FIFOs non-empty and up_almfull low, grants rotate 0,1,..,NUM_REQ-1,0,... Within one requester, order is strict FIFO.
- rr_ptr wrap: NUM_REQ-1 → 0. Indices >= NUM_REQ are never granted.

Optional Feature:
- Macro: VAI_ARB_PERF_CNT_EN.
- When defined: perf_grant_cnt[i] increments by 1 per grant to i. 32-bit counter that saturates at 0xFFFFFFFF (no wrap); cleared by reset.
- When undefined: perf_grant_cnt is tied to 0 and no counter flops are built. All other behaviour is identical.

Test Plan:
- Reset then single request: push req_data[1]=0xA5 at cycle 5 → out_valid=1, out_data=0xA5, out_id=1 at cycle 7; no other out_valid.
- All 3 requesters push 4 entries each at once, up_almfull=0 → 12 beats on consecutive cycles with out_id sequence 0,1,2,0,1,2,...; per-requester data order preserved.
- Requester 0 pushes 5 entries with up_almfull held high (FIFO_DEPTH=8, AF_THRESH=4) → req_almfull[0]=1 the cycle after the 4th push; out_valid stays 0. Release up_almfull → 5 beats drain, req_almfull[0]=0 once count <= 3.
- Requester 2 pushes 9 entries with up_almfull=1 → overflow_err[2]=1 after the 9th push, only 8 beats emitted after release, and overflow_err[2] stays 1.
- Assert SoftReset mid-drain with 3 entries queued → out_valid=0 immediately (asynchronous); after deassert, no beats appear, and rr_ptr=0 is confirmed by a simultaneous push to all requesters granting 0 first.
- With VAI_ARB_PERF_CNT_EN defined, run the 12-beat scenario → perf_grant_cnt = 4,4,4. Without the macro → all zero.
